mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between two requesters: instruction fetch (IF) and load/store (LS).
- Arbitrates between them with round-robin priority and drives the select line of the external mux2 instances that steer address and write data onto the port.
- Sequences each access as a request/ready transaction and returns a one-cycle acknowledge plus registered read data to the winning requester.
- Aborts any access that stalls beyond a bounded wait.

Parameters:
DATA_WIDTH, 32, width of read data path
MAX_WAIT, 15, cycles in BUSY without mem_ready before timeout abort (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
if_req  input  1  fetch request; held high until if_ack
if_ack  output  1  one-cycle pulse: fetch access complete
ls_req  input  1  load/store request; held high until ls_ack
ls_we  input  1  load/store write enable (1 = store)
ls_ack  output  1  one-cycle pulse: load/store access complete
rdata  output  DATA_WIDTH  registered read data, valid in ack cycle
mem_req  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_ready  input  1  memory completes current access
mem_rdata  input  DATA_WIDTH  memory read data, sampled with mem_ready
sel  output  1  mux select for addr/wdata muxes: 0 = IF, 1 = LS
busy  output  1  high while state != IDLE
timeout_err  output  1  one-cycle pulse alongside ack on aborted access

Behaviour:
- Clock and reset are decided: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- Reset (async, any state): state=IDLE; if_ack=ls_ack=mem_req=mem_we=sel=busy=timeout_err=0; rdata=0; wait counter=0; last_grant=1 (LS), so IF wins the first tie.
- FSM, all outputs registered:
  - IDLE: no request -> stay. Only if_req -> grant IF. Only ls_req -> grant LS. Both -> grant the requester != last_grant. On grant: sel<=winner, last_grant<=winner, mem_req<=1, mem_we<=(winner==LS)&ls_we, counter<=0, go BUSY.
  - BUSY: mem_req held 1; sel and mem_we frozen for the whole transaction, even if requests change.
    - mem_ready=1 -> rdata<=mem_rdata (stores also capture it; value is don't-care to the requester), winner's ack<=1, mem_req<=0, mem_we<=0, go RESP.
    - Else counter++. When counter reaches MAX_WAIT-1 with mem_ready still low -> rdata<=0, ack<=1, timeout_err<=1, mem_req<=0, go RESP.
    - mem_ready on the final wait cycle counts as success; no timeout_err.
  - RESP: ack and timeout_err high for exactly this one cycle. No arbitration here, because requesters drop req after seeing ack. Next cycle -> IDLE with acks cleared.
- Latency: grant registered one cycle after req is seen in IDLE. Ack appears one cycle after mem_ready. Minimum transaction is 3 cycles (IDLE -> BUSY -> RESP).
- sel retains its last value in IDLE/RESP; the external muxes may steer stale addresses while mem_req=0.
- A requester dropping req mid-transaction does not abort it; ack is still issued.
- Fairness: with both requesting continuously, grants strictly alternate.
- busy = (state != IDLE).

Test Plan:
- Reset mid-BUSY: assert rst_n=0 during an LS access -> all outputs 0 immediately (asynchronous), state IDLE. After release with both requesting -> IF granted first (sel=0).
- Single fetch: if_req=1, memory returns mem_ready with mem_rdata=32'hDEADBEEF two cycles after mem_req -> sel=0, mem_we=0; if_ack pulses for 1 cycle with rdata=32'hDEADBEEF; ls_ack stays 0.
- Store: ls_req=1, ls_we=1, mem_ready after 1 cycle -> sel=1, mem_we=1 throughout BUSY; ls_ack is a 1-cycle pulse; timeout_err=0.
- Contention: if_req and ls_req both held high for 4 transactions -> grant order IF, LS, IF, LS; each ack goes only to the matching requester; no back-to-back grants without a RESP cycle between them.
- Timeout: ls_req=1, mem_ready held 0 -> after MAX_WAIT=15 cycles in BUSY, ls_ack and timeout_err pulse together, rdata=0, mem_req drops. Repeat with mem_ready=1 on the 15th cycle -> ls_ack only, no timeout_err.
- Request withdrawn: if_req pulsed for 1 cycle -> the transaction still completes and if_ack still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Each access runs IDLE -> BUSY -> RESP; a stall longer than MAX_WAIT cycles is aborted.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  output logic                  if_ack,
  input  logic                  ls_req,
  input  logic                  ls_we,
  output logic                  ls_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  sel,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         wait_cnt, wait_cnt_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  winner;
  logic                  sel_nxt, mem_req_nxt, mem_we_nxt;
  logic                  if_ack_nxt, ls_ack_nxt, timeout_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;

  // On a tie the requester that did not win last time goes next (0 = IF, 1 = LS).
  assign winner = (if_req && ls_req) ? ~last_grant : ls_req;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    last_grant_nxt = last_grant;
    sel_nxt        = sel;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    if_ack_nxt     = 1'b0;
    ls_ack_nxt     = 1'b0;
    timeout_nxt    = 1'b0;
    rdata_nxt      = rdata;

    unique case (state)
      IDLE: begin
        if (if_req || ls_req) begin
          sel_nxt        = winner;
          last_grant_nxt = winner;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = winner & ls_we;
          wait_cnt_nxt   = '0;
          state_nxt      = BUSY;
        end
      end
      BUSY: begin
        // A ready on the final wait cycle still counts as a normal completion.
        if (mem_ready) begin
          rdata_nxt   = mem_rdata;
          if_ack_nxt  = ~sel;
          ls_ack_nxt  = sel;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          state_nxt   = RESP;
        end else if (wait_cnt == LAST_WAIT) begin
          rdata_nxt   = '0;
          if_ack_nxt  = ~sel;
          ls_ack_nxt  = sel;
          timeout_nxt = 1'b1;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          state_nxt   = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      RESP: begin
        // Requesters drop req on seeing ack, so no arbitration happens here.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_grant resets to LS so that IF wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      last_grant  <= 1'b1;
      sel         <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      if_ack      <= 1'b0;
      ls_ack      <= 1'b0;
      timeout_err <= 1'b0;
      rdata       <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      last_grant  <= last_grant_nxt;
      sel         <= sel_nxt;
      mem_req     <= mem_req_nxt;
      mem_we      <= mem_we_nxt;
      if_ack      <= if_ack_nxt;
      ls_ack      <= ls_ack_nxt;
      timeout_err <= timeout_nxt;
      rdata       <= rdata_nxt;
    end
  end

endmodule
